// File: rtl/asym_bram_gather.sv
// Asymmetric gather buffer: narrow lane-addressed writes, wide all-lane reads with written tracking.
// Optional per-entry parity is enabled by defining GATHER_PARITY_EN.
module asym_bram_gather #(
  parameter int unsigned DW_A    = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned DEPTH_W = 512
) (
  input  logic                                         CLK,
  input  logic                                         RST_N,
  input  logic                                         CLR,
  input  logic [DW_A-1:0]                              DIN_A,
  input  logic [$clog2(DEPTH_W)+$clog2(RATIO)-1:0]     ADDR_A,
  input  logic                                         W_A,
  input  logic                                         EN_A,
  input  logic                                         AUTO_A,
  input  logic                                         PINJ_A,
  output logic [$clog2(DEPTH_W)+$clog2(RATIO)-1:0]     WPTR_A,
  output logic                                         FULL_A,
  input  logic [$clog2(DEPTH_W)-1:0]                   ADDR_B,
  input  logic                                         EN_B,
  output logic [DW_A*RATIO-1:0]                        DOUT_B,
  output logic                                         VALID_B,
  output logic                                         COMPLETE_B,
  output logic [RATIO-1:0]                             PERR_B
);

  localparam int unsigned DW_B = DW_A * RATIO;
  localparam int unsigned AW_B = $clog2(DEPTH_W);
  localparam int unsigned LW   = $clog2(RATIO);
  localparam int unsigned AW_A = AW_B + LW;
`ifdef GATHER_PARITY_EN
  localparam int unsigned EW   = DW_A + 1;
`else
  localparam int unsigned EW   = DW_A;
`endif

  logic [AW_A-1:0]  wptr_q;
  logic             full_q;
  logic             valid_q;
  logic [RATIO-1:0] mask_q [DEPTH_W];
  logic [RATIO-1:0] rd_mask_q;
  logic [RATIO-1:0] perr;

  logic             wr;
  logic [AW_A-1:0]  waddr;
  logic [LW-1:0]    wlane;
  logic [AW_B-1:0]  widx;
  logic [EW-1:0]    wentry;

  // CLR wins over any write issued in the same cycle.
  always_comb begin
    wr    = EN_A && W_A && !CLR;
    waddr = AUTO_A ? wptr_q : ADDR_A;
    wlane = waddr[AW_A-1:AW_B];
    widx  = waddr[AW_B-1:0];
  end

`ifdef GATHER_PARITY_EN
  assign wentry = {(^DIN_A) ^ PINJ_A, DIN_A};
`else
  logic unused_pinj;
  assign unused_pinj = PINJ_A;
  assign wentry      = DIN_A;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q <= '0;
      full_q <= 1'b0;
    end else if (CLR) begin
      wptr_q <= '0;
      full_q <= 1'b0;
    end else if (wr && AUTO_A) begin
      wptr_q <= wptr_q + 1'b1;
      if (wptr_q == {AW_A{1'b1}}) full_q <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < int'(DEPTH_W); i++) mask_q[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < int'(DEPTH_W); i++) mask_q[i] <= '0;
    end else if (wr) begin
      mask_q[widx][wlane] <= 1'b1;
    end
  end

  // Non-blocking capture gives read-first behaviour against same-cycle writes and clears.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_mask_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= EN_B;
      if (EN_B) rd_mask_q <= mask_q[ADDR_B];
    end
  end

  for (genvar l = 0; l < int'(RATIO); l++) begin : g_lane
    logic [EW-1:0] mem [DEPTH_W];
    logic [EW-1:0] rd_q;

    always_ff @(posedge CLK) begin
      if (wr && (wlane == LW'(l))) mem[widx] <= wentry;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        rd_q <= '0;
      end else if (EN_B) begin
        rd_q <= mem[ADDR_B];
      end
    end

    assign DOUT_B[l*DW_A +: DW_A] = rd_q[DW_A-1:0];

`ifdef GATHER_PARITY_EN
    // Stored bit is even parity of the data, so a set mismatch means corruption or injection.
    assign perr[l] = (rd_q[DW_A] != (^rd_q[DW_A-1:0])) && rd_mask_q[l];
`else
    assign perr[l] = 1'b0;
`endif
  end

  assign WPTR_A     = wptr_q;
  assign FULL_A     = full_q;
  assign VALID_B    = valid_q;
  assign COMPLETE_B = &rd_mask_q;
  assign PERR_B     = perr;

  logic [DW_B-1:0] unused_dw_b;
  assign unused_dw_b = DOUT_B;

endmodule
